atd_block_unpacker: RTL and testbench

Consumes each 128-bit block from the ATD receive stage and streams it out as 32-bit words to the downstream datapath. It sits directly after the ATD receive stage. On the upstream side it uses that stage's data_ready/data_taken handshake. On the downstream side it uses a valid/ready handshake with back-pressure. It keeps a running count of completed blocks for status reporting.

---
 rtl/atd_pkg.sv | 18 +
 rtl/atd_block_unpacker.sv | 107 ++++++++++
 tb/tb_atd_block_unpacker.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atd_pkg.sv
// Shared definitions for the ATD block unpacker.
//   atd_state_t   : unpacker FSM states
//   ATD_BLOCK_W   : default captured block width
//   ATD_WORD_W    : default output word width
//   ATD_CNT_W     : default completed-block counter width
package atd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } atd_state_t;

   localparam int ATD_BLOCK_W = 128;
   localparam int ATD_WORD_W  = 32;
   localparam int ATD_CNT_W   = 8;

endpackage

// File: rtl/atd_block_unpacker.sv
// Captures one BLOCK_W block from the ATD receive stage (data_ready /
// data_taken handshake) and streams it downstream as WORD_W words, most
// significant word first, over a valid/ready handshake. Counts fully
// transferred blocks.
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   data_ready    upstream block available (held until data_taken)
//   ATD_parallel  upstream block, stable while data_ready=1
//   data_taken    one-cycle capture acknowledge (state LOAD)
//   word_out      current output word
//   word_valid    word_out holds a valid word
//   word_ready    downstream accepts word_out this cycle
//   word_idx      index of current word, 0 = most significant
//   last_word     word_valid at the final index
//   busy          FSM not in IDLE
//   block_count   completed blocks, wraps silently
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for data_ready; capture block into buffer on it
// LOAD  | data_taken pulse; upstream drops data_ready after this cycle
// SEND  | presenting buffer words; advance word_idx on each handshake
module atd_block_unpacker
   import atd_pkg::*;
#(
   parameter  int BLOCK_W = ATD_BLOCK_W,
   parameter  int WORD_W  = ATD_WORD_W,
   parameter  int CNT_W   = ATD_CNT_W,
   localparam int N_WORDS = BLOCK_W / WORD_W,
   localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               data_ready,
   input  logic [BLOCK_W-1:0] ATD_parallel,
   output logic               data_taken,
   output logic [WORD_W-1:0]  word_out,
   output logic               word_valid,
   input  logic               word_ready,
   output logic [IDX_W-1:0]   word_idx,
   output logic               last_word,
   output logic               busy,
   output logic [CNT_W-1:0]   block_count
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

   atd_state_t         state;
   logic [BLOCK_W-1:0] buffer;

   // data_taken and word_valid are registered alongside the state so they
   // are glitch-free and exactly track LOAD and SEND respectively.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         buffer      <= '0;
         word_idx    <= '0;
         block_count <= '0;
         data_taken  <= 1'b0;
         word_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (data_ready) begin
                  buffer     <= ATD_parallel;
                  word_idx   <= '0;
                  data_taken <= 1'b1;
                  state      <= LOAD;
               end
            end

            LOAD: begin
               data_taken <= 1'b0;
               word_valid <= 1'b1;
               state      <= SEND;
            end

            SEND: begin
               if (word_ready) begin
                  if (word_idx == IDX_LAST) begin
                     block_count <= block_count + CNT_W'(1);
                     word_valid  <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     word_idx <= word_idx + IDX_W'(1);
                  end
               end
            end

            default: begin
               data_taken <= 1'b0;
               word_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   // Word 0 is the top slice of the buffer; the buffer is zero under reset,
   // so word_out is zero there too.
   assign word_out  = buffer[BLOCK_W - 1 - WORD_W * int'(word_idx) -: WORD_W];
   assign last_word = word_valid && (word_idx == IDX_LAST);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_atd_block_unpacker.sv
`timescale 1ns/1ps
module tb_atd_block_unpacker;

   localparam int BLOCK_W = 128;
   localparam int WORD_W  = 32;
   localparam int CNT_W   = 8;
   localparam int N       = BLOCK_W / WORD_W;

   logic               clk;
   logic               n_rst;
   logic               data_ready;
   logic [BLOCK_W-1:0] ATD_parallel;
   logic               data_taken;
   logic [WORD_W-1:0]  word_out;
   logic               word_valid;
   logic               word_ready;
   logic [1:0]         word_idx;
   logic               last_word;
   logic               busy;
   logic [CNT_W-1:0]   block_count;

   atd_block_unpacker #(
      .BLOCK_W (BLOCK_W),
      .WORD_W  (WORD_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .data_ready   (data_ready),
      .ATD_parallel (ATD_parallel),
      .data_taken   (data_taken),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .word_idx     (word_idx),
      .last_word    (last_word),
      .busy         (busy),
      .block_count  (block_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [WORD_W-1:0] w;
      logic [1:0]        idx;
      logic              last;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   dt_cnt = 0;
   int   cyc    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_block(input logic [BLOCK_W-1:0] blk);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.w    = blk[BLOCK_W - 1 - WORD_W * i -: WORD_W];
         e.idx  = 2'(i);
         e.last = (i == N - 1);
         sb.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_taken();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!data_taken && n < 60);
      if (!data_taken) chk("taken_timeout", data_taken, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 60);
      if (busy) chk("idle_timeout", busy, 0);
   endtask

   task automatic wait_word(input logic [1:0] idx);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(word_valid && word_idx == idx) && n < 60);
      if (!(word_valid && word_idx == idx)) chk("word_timeout", word_idx, idx);
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard: every accepted word is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      if (data_taken) dt_cnt++;
      if (n_rst && word_valid && word_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("word", word_out, e.w);
            chk("idx", word_idx, e.idx);
            chk("last", last_word, e.last);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   localparam logic [BLOCK_W-1:0] K1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [BLOCK_W-1:0] K2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [BLOCK_W-1:0] K3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
   localparam logic [BLOCK_W-1:0] K4 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
   localparam logic [BLOCK_W-1:0] K5 = 128'h11111111_22222222_33333333_44444444;

   initial begin
      int t0;
      int last_cyc;
      int stall_cnt;
      logic [BLOCK_W-1:0] blk;

      // Reset with upstream and downstream both active.
      n_rst        = 1'b0;
      data_ready   = 1'b1;
      word_ready   = 1'b1;
      ATD_parallel = K1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_outs", {data_taken, word_valid, word_out, word_idx, last_word, busy, block_count}, 0);
      end
      chk("rst_no_taken", dt_cnt, 0);
      tick();
      data_ready = 1'b0;
      n_rst      = 1'b1;
      tick();

      // Single block, no back-pressure.
      ATD_parallel = K1;
      data_ready   = 1'b1;
      push_block(K1);
      @(negedge clk);
      chk("t2_pre_taken", data_taken, 0);
      @(negedge clk);
      chk("t2_taken", data_taken, 1);
      chk("t2_load_valid", word_valid, 0);
      data_ready = 1'b0;
      @(negedge clk);
      chk("t2_first_valid", word_valid, 1);
      chk("t2_taken_pulse", data_taken, 0);
      chk("t2_first_word", word_out, 32'h00112233);
      repeat (3) @(negedge clk);
      chk("t2_last", last_word, 1);
      @(negedge clk);
      chk("t2_done_busy", busy, 0);
      chk("t2_done_valid", word_valid, 0);
      chk("t2_count", block_count, 1);

      // Back-pressure on word 1 for three cycles.
      tick();
      ATD_parallel = K2;
      data_ready   = 1'b1;
      push_block(K2);
      wait_taken();
      data_ready = 1'b0;
      wait_word(2'd0);
      tick();
      word_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_hold_word", word_out, 32'h89ABCDEF);
         chk("t3_hold_idx", word_idx, 1);
         chk("t3_hold_valid", word_valid, 1);
         tick();
      end
      word_ready = 1'b1;
      stall_cnt  = 0;
      do begin
         @(negedge clk);
         stall_cnt++;
      end while (busy && stall_cnt < 20);
      chk("t3_tail_cycles", stall_cnt, 4);
      chk("t3_count", block_count, 2);

      // data_ready held high, ATD_parallel changed mid-transfer.
      tick();
      ATD_parallel = K3;
      data_ready   = 1'b1;
      push_block(K3);
      t0 = dt_cnt;
      wait_taken();
      @(negedge clk);
      ATD_parallel = K4;
      push_block(K4);
      wait_idle();
      chk("t4_one_taken", dt_cnt - t0, 1);
      @(negedge clk);
      chk("t4_recapture", data_taken, 1);
      data_ready = 1'b0;
      wait_idle();
      chk("t4_count", block_count, 4);

      // Reset in the middle of a transfer: partial block discarded.
      tick();
      ATD_parallel = K5;
      data_ready   = 1'b1;
      push_block(K5);
      wait_taken();
      wait_word(2'd2);
      tick();
      n_rst = 1'b0;
      #1;
      chk("t5_rst_valid", word_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_word", word_out, 0);
      chk("t5_rst_count", block_count, 0);
      sb.delete();
      tick();
      n_rst = 1'b1;
      push_block(K5);
      wait_taken();
      data_ready = 1'b0;
      @(negedge clk);
      chk("t5_restart_idx", word_idx, 0);
      chk("t5_restart_word", word_out, 32'h11111111);
      wait_idle();
      chk("t5_count", block_count, 1);

      // Counter wrap: 256 back-to-back blocks from a clean counter.
      tick();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      tick();
      blk          = {$urandom, $urandom, $urandom, $urandom};
      ATD_parallel = blk;
      data_ready   = 1'b1;
      push_block(blk);
      last_cyc = 0;
      for (int b = 0; b < 256; b++) begin
         wait_taken();
         if (b > 0) chk("t6_period", cyc - last_cyc, N + 2);
         last_cyc = cyc;
         if (b == 255) begin
            chk("t6_count_255", block_count, 255);
            data_ready = 1'b0;
         end else begin
            blk          = {$urandom, $urandom, $urandom, $urandom};
            ATD_parallel = blk;
            push_block(blk);
         end
      end
      wait_idle();
      chk("t6_count_wrap", block_count, 0);

      // word_ready while idle has no effect.
      repeat (3) @(negedge clk);
      chk("idle_valid", word_valid, 0);
      chk("sb_empty", sb.size(), 0);
      chk("taken_total", dt_cnt, 262);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
